// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - circular writeback queue draining one entry per cycle into the register file
// Optional bypass lookup enabled by macro WBQ_BYPASS_EN.
module regfile_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [4:0]             InReg,
  input  logic [31:0]            InData,
  input  logic                   Hold,
  output logic [4:0]             WriteRegister,
  output logic [31:0]            WriteData,
  output logic                   RegWrite,
  output logic [$clog2(DEPTH):0] Count,
  input  logic [4:0]             LookupReg,
  output logic                   LookupHit,
  output logic [31:0]            LookupData
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    q_reg  [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          accept;
  logic          push;
  logic          pop;

  // Ready looks only at occupancy so upstream never sees a combinational path through Hold.
  assign InReady = (count < CW'(DEPTH));
  assign accept  = InValid && InReady;
  assign push    = accept && (InReg != 5'd0);
  assign pop     = (count != '0) && !Hold;
  assign Count   = count;

  always_ff @(posedge Clk) begin
    if (!Reset && push) begin
      q_reg[wr_ptr]  <= InReg;
      q_data[wr_ptr] <= InData;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + AW'(1);
        WriteRegister <= q_reg[rd_ptr];
        WriteData     <= q_data[rd_ptr];
      end
      RegWrite <= pop;
      count    <= count + CW'(push) - CW'(pop);
    end
  end

`ifdef WBQ_BYPASS_EN
  // Scan oldest to youngest so the last match left standing is the youngest write.
  always_comb begin
    LookupHit  = 1'b0;
    LookupData = '0;
    if (LookupReg != 5'd0) begin
      if (RegWrite && (WriteRegister == LookupReg)) begin
        LookupHit  = 1'b1;
        LookupData = WriteData;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < count) && (q_reg[rd_ptr + AW'(i)] == LookupReg)) begin
          LookupHit  = 1'b1;
          LookupData = q_data[rd_ptr + AW'(i)];
        end
      end
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^LookupReg;
  assign LookupHit     = 1'b0;
  assign LookupData    = '0;
`endif

endmodule

// File: doc/regfile_wb_queue.md
REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, which sets the number of queue entries (power of two, 2..16).
REQ-002 The block SHALL have port Clk, input, 1, system clock; all state updates on posedge.
REQ-003 The block SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port InValid, input, 1, writeback request valid.
REQ-005 The block SHALL have port InReady, output, 1, queue can accept a request.
REQ-006 The block SHALL have port InReg, input, 5, destination register number.
REQ-007 The block SHALL have port InData, input, 32, destination data.
REQ-008 The block SHALL have port Hold, input, 1, suspends draining to the register file.
REQ-009 The block SHALL have port WriteRegister, output, 5, register address to the register file.
REQ-010 The block SHALL have port WriteData, output, 32, data to the register file.
REQ-011 The block SHALL have port RegWrite, output, 1, register-file write enable.
REQ-012 The block SHALL have port Count, output, $clog2(DEPTH)+1, number of stored entries.
REQ-013 The block SHALL have port LookupReg, input, 5, register number for the bypass query.
REQ-014 The block SHALL have port LookupHit, output, 1, a pending write to LookupReg exists.
REQ-015 The block SHALL have port LookupData, output, 32, data of the youngest pending write to LookupReg.

Function
REQ-016 A request SHALL be accepted on a posedge where InValid=1 and InReady=1.
REQ-017 InReady SHALL equal (Count < DEPTH) and SHALL NOT depend on InValid or on a same-cycle pop.
REQ-018 An accepted request with InReg=0 SHALL be consumed without being stored, since $zero is never written.
REQ-019 Storage SHALL be a circular FIFO with wrapping read and write pointers, and order SHALL be preserved.
REQ-020 On a posedge with Count>0 and Hold=0, the head entry SHALL be popped into registered WriteRegister/WriteData, and RegWrite SHALL be 1 for the following cycle only.
REQ-021 On a posedge with no pop, RegWrite SHALL be 0, and WriteRegister/WriteData SHALL hold their previous values.
REQ-022 Outputs are registered at posedge so that they are stable for the register file's negedge write.
REQ-023 A push and a pop on the same edge SHALL both take effect, and Count SHALL be unchanged.
REQ-024 Latency: a request accepted into an empty queue at edge N SHALL be popped at edge N+1, with RegWrite high between edges N+1 and N+2 when Hold=0.
REQ-025 Hold=1 SHALL block popping only; pushes SHALL continue until full.
REQ-026 Data values SHALL be passed unmodified, with no arithmetic performed.

Reset
REQ-027 On a posedge with Reset=1: pointers and Count SHALL be 0, RegWrite 0, WriteRegister 0, WriteData 0, and LookupHit 0. InReady SHALL be 1 after the edge.
REQ-028 Reset SHALL take priority over a simultaneous push or pop; in-flight entries SHALL be discarded and no RegWrite pulse SHALL follow.

Configuration
REQ-029 When macro WBQ_BYPASS_EN is defined, LookupHit/LookupData SHALL be combinational.
- The search covers the queue entries and the output register while RegWrite=1.
- The youngest match wins.
- LookupReg=0 SHALL never hit.
REQ-030 When WBQ_BYPASS_EN is undefined, LookupHit and LookupData SHALL be constant 0, and LookupReg SHALL be ignored.

Verification
REQ-031 Reset, then push reg 8 with 0xFFFFFFFF -> RegWrite=1 with WriteRegister=8 and WriteData=0xFFFFFFFF in the cycle after the second edge; Count returns to 0.
REQ-032 Hold=1, push 4 entries (regs 2, 9, 16, 3) -> Count=4, InReady=0, and a 5th push is not accepted; release Hold -> RegWrite pulses on 4 consecutive cycles in order 2, 9, 16, 3.
REQ-033 Push reg 0 with 0x12345678 -> accepted, Count stays 0, and no RegWrite pulse.
REQ-034 With WBQ_BYPASS_EN defined: Hold=1, push reg 9 = 0x0F0F0F0F then reg 9 = 0xAAAA5555, LookupReg=9 -> LookupHit=1 and LookupData=0xAAAA5555. Without the macro -> LookupHit=0.
REQ-035 Full queue with Hold=0 and InValid=1 -> one pop and no push that edge (InReady was 0), then alternating push and pop keeps Count=3 while pointers wrap.
REQ-036 Reset asserted with Count=3 and a pop due -> RegWrite=0 next cycle, Count=0, and previously queued registers are never written.
